// File: rtl/dcache_ctrl_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate data cache:
// hit detection, victim selection, writeback, line fill, LRU update and perf counters.
module dcache_ctrl_nway #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned CNT_W = 32,
   localparam int unsigned WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   input  logic [WAYS-1:0]  hit_way,
   input  logic [WAYS-1:0]  valid_way,
   input  logic [WAYS-1:0]  dirty_way,
   input  logic [WAY_W-1:0] lru_way,
   output logic [WAY_W-1:0] way_sel,
   output logic             load_line,
   output logic             load_tag,
   output logic             cpu_wr_en,
   output logic             set_dirty,
   output logic             clr_dirty,
   output logic             lru_update,
   output logic             addr_out_sel,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

   state_t           state_q, state_d;
   logic [WAY_W-1:0] victim_q, victim_d;
   logic [WAY_W-1:0] hit_idx, inv_idx, victim;
   logic             hit_any, inv_any, req;
   logic             hit_inc, miss_inc, wb_inc;

   // Lowest-index priority encoders for hit and invalid ways
   always_comb begin
      hit_idx = '0;
      inv_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (hit_way[i])    hit_idx = WAY_W'(i);
         if (!valid_way[i]) inv_idx = WAY_W'(i);
      end
      hit_any = |hit_way;
      inv_any = ~&valid_way;
      victim  = inv_any ? inv_idx : lru_way;
      req     = mem_read | mem_write;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         victim_q   <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         if (hit_inc && hit_count != {CNT_W{1'b1}})   hit_count  <= hit_count + CNT_W'(1);
         if (miss_inc && miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
         if (wb_inc && wb_count != {CNT_W{1'b1}})     wb_count   <= wb_count + CNT_W'(1);
      end
   end

   // Next state and datapath strobes; everything is forced quiet while rst is high
   always_comb begin
      state_d      = state_q;
      victim_d     = victim_q;
      way_sel      = victim_q;
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      load_line    = 1'b0;
      load_tag     = 1'b0;
      cpu_wr_en    = 1'b0;
      set_dirty    = 1'b0;
      clr_dirty    = 1'b0;
      lru_update   = 1'b0;
      addr_out_sel = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      wb_inc       = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (req && hit_any) begin
                  mem_resp   = 1'b1;
                  lru_update = 1'b1;
                  way_sel    = hit_idx;
                  cpu_wr_en  = mem_write;
                  set_dirty  = mem_write;
                  hit_inc    = 1'b1;
               end else if (req) begin
                  victim_d = victim;
                  miss_inc = 1'b1;
                  state_d  = (valid_way[victim] && dirty_way[victim]) ? WB : FILL;
               end
            end
            WB: begin
               pmem_write   = 1'b1;
               addr_out_sel = 1'b1;
               if (pmem_resp) begin
                  wb_inc  = 1'b1;
                  state_d = FILL;
               end
            end
            FILL: begin
               pmem_read = 1'b1;
               if (pmem_resp) begin
                  load_line = 1'b1;
                  load_tag  = 1'b1;
                  clr_dirty = 1'b1;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Directed bench for dcache_ctrl_nway: hit vector table plus miss, writeback,
// victim-choice, saturation and reset-mid-fill sequences.
module tb_dcache_ctrl_nway;

   logic       clk, rst;
   logic       mem_read, mem_write, mem_resp;
   logic       pmem_read, pmem_write, pmem_resp;
   logic [3:0] hit_way, valid_way, dirty_way;
   logic [1:0] lru_way, way_sel;
   logic       load_line, load_tag, cpu_wr_en, set_dirty, clr_dirty, lru_update, addr_out_sel;
   logic [1:0] hit_count, miss_count, wb_count;

   int checks = 0;
   int errors = 0;

   dcache_ctrl_nway #(.WAYS(4), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
      .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way), .lru_way(lru_way),
      .way_sel(way_sel), .load_line(load_line), .load_tag(load_tag),
      .cpu_wr_en(cpu_wr_en), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
      .lru_update(lru_update), .addr_out_sel(addr_out_sel),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic       rd, wr, pr;
      logic [3:0] hit;
      logic       resp, lru, cwe, sdirty, chk_way;
      logic [1:0] wsel;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] strobes();
      return {mem_resp, pmem_read, pmem_write, load_line, load_tag,
              cpu_wr_en, set_dirty, clr_dirty, lru_update, addr_out_sel};
   endfunction

   task automatic idle_in();
      mem_read = 0; mem_write = 0; pmem_resp = 0;
      hit_way = 0; valid_way = 4'b1111; dirty_way = 0; lru_way = 0;
   endtask

   // Two cycles of reset with random inputs; strobes must stay quiet throughout
   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rst = 1;
         {mem_read, mem_write, pmem_resp} = 3'($urandom);
         hit_way = 4'($urandom); valid_way = 4'($urandom);
         dirty_way = 4'($urandom); lru_way = 2'($urandom);
         #1 chk("reset_strobes", 32'(strobes()), 0);
      end
      @(negedge clk);
      rst = 0;
      idle_in();
      #1;
      chk("reset_hit_count", 32'(hit_count), 0);
      chk("reset_miss_count", 32'(miss_count), 0);
      chk("reset_wb_count", 32'(wb_count), 0);
   endtask

   // Inputs change just after negedge, outputs sampled 1ns later
   task automatic step();
      @(negedge clk);
   endtask

   vec_t vt[6];

   initial begin
      rst = 1;
      idle_in();

      vt[0] = '{rd:1, wr:0, pr:0, hit:4'b0100, resp:1, lru:1, cwe:0, sdirty:0, chk_way:1, wsel:2};
      vt[1] = '{rd:0, wr:1, pr:0, hit:4'b0110, resp:1, lru:1, cwe:1, sdirty:1, chk_way:1, wsel:1};
      vt[2] = '{rd:1, wr:1, pr:0, hit:4'b1001, resp:1, lru:1, cwe:1, sdirty:1, chk_way:1, wsel:0};
      vt[3] = '{rd:0, wr:0, pr:1, hit:4'b1111, resp:0, lru:0, cwe:0, sdirty:0, chk_way:0, wsel:0};
      vt[4] = '{rd:1, wr:0, pr:0, hit:4'b1000, resp:1, lru:1, cwe:0, sdirty:0, chk_way:1, wsel:3};
      vt[5] = '{rd:0, wr:0, pr:0, hit:4'b0000, resp:0, lru:0, cwe:0, sdirty:0, chk_way:0, wsel:0};

      do_reset();

      // Hit path table: same-cycle response, no memory traffic
      for (int i = 0; i < 6; i++) begin
         step();
         mem_read = vt[i].rd; mem_write = vt[i].wr; pmem_resp = vt[i].pr;
         hit_way = vt[i].hit;
         #1;
         chk($sformatf("v%0d_mem_resp", i), 32'(mem_resp), 32'(vt[i].resp));
         chk($sformatf("v%0d_lru_update", i), 32'(lru_update), 32'(vt[i].lru));
         chk($sformatf("v%0d_cpu_wr_en", i), 32'(cpu_wr_en), 32'(vt[i].cwe));
         chk($sformatf("v%0d_set_dirty", i), 32'(set_dirty), 32'(vt[i].sdirty));
         chk($sformatf("v%0d_pmem", i), 32'({pmem_read, pmem_write, load_line}), 0);
         if (vt[i].chk_way) chk($sformatf("v%0d_way_sel", i), 32'(way_sel), 32'(vt[i].wsel));
         if (i == 0) begin
            step(); idle_in(); #1;
            chk("read_hit_count", 32'(hit_count), 1);
         end
      end
      step(); idle_in(); #1;
      chk("table_hit_count_sat", 32'(hit_count), 3);
      chk("table_miss_count", 32'(miss_count), 0);

      // Clean miss: victim lru_way=3, three fill cycles, then hit
      do_reset();
      step(); mem_read = 1; lru_way = 3; #1;
      chk("cm_idle_resp", 32'(mem_resp), 0);
      chk("cm_idle_pmem", 32'({pmem_read, pmem_write}), 0);
      for (int c = 0; c < 3; c++) begin
         step(); pmem_resp = (c == 2); #1;
         chk($sformatf("cm_fill%0d_pmem_read", c), 32'(pmem_read), 1);
         chk($sformatf("cm_fill%0d_pmem_write", c), 32'(pmem_write), 0);
         chk($sformatf("cm_fill%0d_way_sel", c), 32'(way_sel), 3);
         chk($sformatf("cm_fill%0d_load", c), 32'({load_line, load_tag, clr_dirty}),
             (c == 2) ? 32'h7 : 32'h0);
      end
      step(); pmem_resp = 0; hit_way = 4'b1000; #1;
      chk("cm_hit_resp", 32'(mem_resp), 1);
      chk("cm_hit_pmem_read", 32'(pmem_read), 0);
      chk("cm_hit_way_sel", 32'(way_sel), 3);
      step(); idle_in(); #1;
      chk("cm_miss_count", 32'(miss_count), 1);
      chk("cm_hit_count", 32'(hit_count), 1);
      chk("cm_wb_count", 32'(wb_count), 0);

      // Dirty write miss: writeback of way 1 then fill then write hit
      do_reset();
      step(); mem_write = 1; dirty_way = 4'b0010; lru_way = 1; #1;
      chk("dm_idle_resp", 32'(mem_resp), 0);
      step(); #1;
      chk("dm_wb0_pmem", 32'({pmem_write, addr_out_sel, pmem_read}), 32'b110);
      chk("dm_wb0_way_sel", 32'(way_sel), 1);
      step(); pmem_resp = 1; #1;
      chk("dm_wb1_pmem", 32'({pmem_write, addr_out_sel, pmem_read}), 32'b110);
      step(); #1;
      chk("dm_fill_pmem", 32'({pmem_write, addr_out_sel, pmem_read}), 32'b001);
      chk("dm_fill_load", 32'({load_line, load_tag, clr_dirty}), 32'h7);
      step(); pmem_resp = 0; hit_way = 4'b0010; #1;
      chk("dm_hit", 32'({mem_resp, cpu_wr_en, set_dirty, lru_update}), 32'hF);
      chk("dm_hit_way_sel", 32'(way_sel), 1);
      step(); idle_in(); #1;
      chk("dm_wb_count", 32'(wb_count), 1);
      chk("dm_miss_count", 32'(miss_count), 1);

      // Invalid way 2 is chosen over dirty LRU way 0
      do_reset();
      step(); mem_read = 1; valid_way = 4'b1011; dirty_way = 4'b0001; lru_way = 0; #1;
      step(); pmem_resp = 1; #1;
      chk("iv_no_wb", 32'({pmem_write, pmem_read}), 32'b01);
      chk("iv_way_sel", 32'(way_sel), 2);
      step(); pmem_resp = 0; hit_way = 4'b0100; valid_way = 4'b1111; #1;
      chk("iv_hit", 32'({mem_resp, way_sel}), 32'b110);
      step(); idle_in(); #1;
      chk("iv_wb_count", 32'(wb_count), 0);

      // Saturation, then reset in the middle of a fill
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(); mem_read = 1; hit_way = 4'b0001; #1;
      end
      step(); idle_in(); #1;
      chk("sat_hit_count", 32'(hit_count), 3);
      mem_read = 1;
      step(); #1;
      chk("sat_fill_pmem_read", 32'(pmem_read), 1);
      step(); rst = 1; pmem_resp = 1; #1;
      chk("rf_pmem_read_drop", 32'(pmem_read), 0);
      chk("rf_no_load", 32'({load_line, load_tag, clr_dirty}), 0);
      step(); rst = 0; idle_in(); #1;
      chk("rf_hit_count", 32'(hit_count), 0);
      chk("rf_miss_count", 32'(miss_count), 0);
      chk("rf_idle_pmem", 32'({pmem_read, pmem_write}), 0);
      step(); #1;
      chk("rf_still_idle", 32'({pmem_read, pmem_write}), 0);
      mem_read = 1; hit_way = 4'b0010; #1;
      chk("rf_hit_after", 32'({mem_resp, way_sel}), 32'b101);

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
